// File: rtl/lsu_riscv.sv
// lsu_riscv: multi-cycle RISC-V load/store unit with request/ready memory port,
// load extension, PC stall and misalignment/illegal/timeout error pulse.
module lsu_riscv #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  memi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;
  logic [31:0]     r_addr, r_wdata, r_rd;
  logic [3:0]      r_be;
  logic [1:0]      r_size;
  logic            r_we, r_uns, r_err;
  logic [TO_W-1:0] r_cnt;
  logic [2:0]      w_f3;
  logic            w_req, w_illegal, w_misal, w_start, w_reject;
  logic            w_busy, w_tmo, w_done;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_lane, w_ext;
  assign w_f3      = memi_i[4:2];
  assign w_req     = memi_i[1] | memi_i[0];
  // size 11, load func3 110/111 and any store with func3[2] set are illegal
  assign w_illegal = (w_f3[1:0] == 2'b11) | (w_f3[2] & (w_f3[1] | memi_i[1]));
  assign w_misal   = ((w_f3[1:0] == 2'b01) & addr_i[0]) | ((w_f3[1:0] == 2'b10) & |addr_i[1:0]);
  assign w_start   = (r_state == S_IDLE) & w_req & ~w_illegal & ~w_misal;
  assign w_reject  = (r_state == S_IDLE) & w_req & (w_illegal | w_misal);
  assign w_busy    = r_state == S_BUSY;
  assign w_tmo     = w_busy & ~mem_ready_i & (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_done    = w_busy & (mem_ready_i | w_tmo);
  assign w_be      = (w_f3[1:0] == 2'b00) ? 4'b0001 << addr_i[1:0] :
                     (w_f3[1:0] == 2'b01) ? 4'b0011 << addr_i[1:0] : 4'b1111;
  assign w_wdata   = (w_f3[1:0] == 2'b00) ? {4{wdata_i[7:0]}} :
                     (w_f3[1:0] == 2'b01) ? {2{wdata_i[15:0]}} : wdata_i;
  assign w_lane    = mem_rdata_i >> {r_addr[1:0], 3'b000};
  assign w_ext     = (r_size == 2'b00) ? {{24{~r_uns & w_lane[7]}}, w_lane[7:0]} :
                     (r_size == 2'b01) ? {{16{~r_uns & w_lane[15]}}, w_lane[15:0]} : w_lane;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = w_done ? S_DONE : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_reject | w_tmo;
      r_cnt   <= (w_busy && !w_done) ? r_cnt + TO_W'(1) : '0;
      if (w_start) begin
        r_addr  <= addr_i;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_size  <= w_f3[1:0];
        r_we    <= memi_i[1];
        r_uns   <= w_f3[2];
      end
      if (w_reject || w_tmo)
        r_rd <= '0;
      else if (w_busy && mem_ready_i && !r_we)
        r_rd <= w_ext;
    end
  end
  assign stall_o     = w_start | w_busy;
  assign mem_req_o   = w_busy;
  assign mem_we_o    = w_busy & r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = {r_addr[31:2], 2'b00};
  assign mem_wdata_o = r_wdata;
  assign rd_o        = r_rd;
  assign err_o       = r_err;
endmodule
